// File: rtl/ct_spsram_arb_ctrl.sv
// Shared-access controller for one single-port SRAM: zero-fills the array
// after reset, then round-robins two requesters onto the port and returns
// read data to the issuing requester two cycles after its grant.
module ct_spsram_arb_ctrl #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 128,
  parameter bit          INIT_EN    = 1'b1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  p0_req,
  input  logic                  p0_wr,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic [DATA_WIDTH-1:0] p0_wmask,
  input  logic                  p1_req,
  input  logic                  p1_wr,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic [DATA_WIDTH-1:0] p1_wmask,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_cen,
  output logic                  ram_gwen,
  output logic [DATA_WIDTH-1:0] ram_wen,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = '1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    ptr_q, ptr_d;
  logic                    s1_vld_q, s1_vld_d;
  logic                    s1_port_q, s1_port_d;
  logic                    p0_rvalid_q, p0_rvalid_d;
  logic                    p1_rvalid_q, p1_rvalid_d;
  logic [DATA_WIDTH-1:0]   p0_rdata_q, p0_rdata_d;
  logic [DATA_WIDTH-1:0]   p1_rdata_q, p1_rdata_d;

  logic                    sel_wr;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [DATA_WIDTH-1:0]   sel_wmask;

  // Round-robin arbiter; grants only in RUN and never while reset is asserted.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (cpurst_b && (state_q == ST_RUN)) begin
      if (p0_req && p1_req) begin
        p0_gnt = ~ptr_q;
        p1_gnt = ptr_q;
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
    end
  end

  // Mux the granted port's request onto a single access.
  always_comb begin
    sel_wr    = p1_gnt ? p1_wr    : p0_wr;
    sel_addr  = p1_gnt ? p1_addr  : p0_addr;
    sel_wdata = p1_gnt ? p1_wdata : p0_wdata;
    sel_wmask = p1_gnt ? p1_wmask : p0_wmask;
  end

  // Next-state, SRAM port drive and read-return pipeline.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    s1_vld_d    = 1'b0;
    s1_port_d   = s1_port_q;
    p0_rvalid_d = 1'b0;
    p1_rvalid_d = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    ram_a       = '0;
    ram_cen     = 1'b1;
    ram_gwen    = 1'b1;
    ram_wen     = '1;
    ram_d       = '0;

    if (cpurst_b) begin
      case (state_q)
        ST_INIT: begin
          if (INIT_EN) begin
            ram_cen  = 1'b0;
            ram_gwen = 1'b0;
            ram_wen  = '0;
            ram_a    = cnt_q;
            if (cnt_q == MAX_ADDR) begin
              state_d = ST_RUN;
            end else begin
              cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (p0_gnt || p1_gnt) begin
            ptr_d   = p0_gnt;
            ram_cen = 1'b0;
            ram_a   = sel_addr;
            if (sel_wr) begin
              ram_gwen = 1'b0;
              ram_wen  = ~sel_wmask;
              ram_d    = sel_wdata;
            end else begin
              s1_vld_d  = 1'b1;
              s1_port_d = p1_gnt;
            end
          end
        end
        default: state_d = ST_INIT;
      endcase
    end

    if (s1_vld_q) begin
      if (s1_port_q) begin
        p1_rvalid_d = 1'b1;
        p1_rdata_d  = ram_q;
      end else begin
        p0_rvalid_d = 1'b1;
        p0_rdata_d  = ram_q;
      end
    end
  end

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_port_q   <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      s1_vld_q    <= s1_vld_d;
      s1_port_q   <= s1_port_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign init_done = (state_q == ST_RUN);

endmodule

// File: tb/tb_ct_spsram_arb_ctrl.sv
// Bench for ct_spsram_arb_ctrl: a 16-entry instance with zero-fill checked
// every cycle against a behavioural model, plus a no-init instance.
module tb_ct_spsram_arb_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          p0_req = 0, p0_wr = 0, p1_req = 0, p1_wr = 0;
  logic [AW-1:0] p0_addr = 0, p1_addr = 0;
  logic [DW-1:0] p0_wdata = 0, p0_wmask = 0, p1_wdata = 0, p1_wmask = 0;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, init_done;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] ram_a;
  logic          ram_cen, ram_gwen;
  logic [DW-1:0] ram_wen, ram_d, ram_q;

  logic          q0_req = 0;
  logic [AW-1:0] q0_addr = 0;
  logic          q0_gnt, q1_gnt, q0_rvalid, q1_rvalid, init_done2;
  logic [DW-1:0] q0_rdata, q1_rdata;
  logic [AW-1:0] ram_a2;
  logic          ram_cen2, ram_gwen2;
  logic [DW-1:0] ram_wen2, ram_d2;
  logic [DW-1:0] ram_q2 = 32'h1234_5678;
  logic          tie0 = 1'b0;
  logic [AW-1:0] tie_a = '0;
  logic [DW-1:0] tie_d = '0;

  ct_spsram_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1'b1)) dut (
    .forever_cpuclk(clk), .cpurst_b(rst_n),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .init_done(init_done), .ram_a(ram_a), .ram_cen(ram_cen), .ram_gwen(ram_gwen),
    .ram_wen(ram_wen), .ram_d(ram_d), .ram_q(ram_q)
  );

  ct_spsram_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1'b0)) dut2 (
    .forever_cpuclk(clk), .cpurst_b(rst_n),
    .p0_req(q0_req), .p0_wr(tie0), .p0_addr(q0_addr), .p0_wdata(tie_d), .p0_wmask(tie_d),
    .p1_req(tie0), .p1_wr(tie0), .p1_addr(tie_a), .p1_wdata(tie_d), .p1_wmask(tie_d),
    .p0_gnt(q0_gnt), .p0_rvalid(q0_rvalid), .p0_rdata(q0_rdata),
    .p1_gnt(q1_gnt), .p1_rvalid(q1_rvalid), .p1_rdata(q1_rdata),
    .init_done(init_done2), .ram_a(ram_a2), .ram_cen(ram_cen2), .ram_gwen(ram_gwen2),
    .ram_wen(ram_wen2), .ram_d(ram_d2), .ram_q(ram_q2)
  );

  // SRAM macro model with garbage initial contents so zero-fill is observable.
  logic [DW-1:0] sram [16];
  initial for (int i = 0; i < 16; i++) sram[i] = 32'hDEAD_0000 | DW'(i);
  always @(posedge clk) begin
    if (!ram_cen) begin
      if (!ram_gwen) sram[ram_a] <= (sram[ram_a] & ram_wen) | (ram_d & ~ram_wen);
      else           ram_q <= sram[ram_a];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Behavioural model: run flag, zero-fill progress, pointer, reference
  // memory and a queue of pending read deliveries keyed by due cycle.
  typedef struct {
    int          due;
    bit          port;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] ref_mem [16];
  rd_t           pend [$];
  logic [DW-1:0] m_rdata [2];
  bit            m_known = 0;
  bit            m_run = 0;
  bit            m_ptr = 0;
  int            m_icnt = 0;

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    logic          e_g0, e_g1, e_rv0, e_rv1, e_cen, e_gwen, gp;
    logic [AW-1:0] e_a, ga;
    logic [DW-1:0] e_wen, e_d;
    rd_t           rd;
    e_g0 = 0; e_g1 = 0; e_rv0 = 0; e_rv1 = 0;
    e_cen = 1; e_gwen = 1; e_a = '0; e_wen = '1; e_d = '0;
    gp = 0; ga = '0;
    while (pend.size() > 0 && pend[0].due == cyc) begin
      rd = pend.pop_front();
      if (rd.port) begin e_rv1 = 1; m_rdata[1] = rd.data; end
      else         begin e_rv0 = 1; m_rdata[0] = rd.data; end
    end
    if (rst_n) begin
      if (!m_run) begin
        e_cen = 0; e_gwen = 0; e_wen = '0; e_a = AW'(m_icnt);
      end else begin
        if (p0_req && (!p1_req || !m_ptr)) e_g0 = 1;
        else if (p1_req)                   e_g1 = 1;
        if (e_g0 || e_g1) begin
          gp = e_g1;
          ga = gp ? p1_addr : p0_addr;
          e_cen = 0; e_a = ga;
          if (gp ? p1_wr : p0_wr) begin
            e_gwen = 0;
            e_wen  = gp ? ~p1_wmask : ~p0_wmask;
            e_d    = gp ? p1_wdata : p0_wdata;
          end
        end
      end
    end
    if (m_known) begin
      chk("p0_gnt", 64'(p0_gnt), 64'(e_g0));
      chk("p1_gnt", 64'(p1_gnt), 64'(e_g1));
      chk("p0_rvalid", 64'(p0_rvalid), 64'(e_rv0));
      chk("p1_rvalid", 64'(p1_rvalid), 64'(e_rv1));
      chk("p0_rdata", 64'(p0_rdata), 64'(m_rdata[0]));
      chk("p1_rdata", 64'(p1_rdata), 64'(m_rdata[1]));
      chk("init_done", 64'(init_done), 64'(rst_n === 1'b1 ? m_run : m_run));
      chk("ram_cen", 64'(ram_cen), 64'(e_cen));
      chk("ram_gwen", 64'(ram_gwen), 64'(e_gwen));
      chk("ram_a", 64'(ram_a), 64'(e_a));
      chk("ram_wen", 64'(ram_wen), 64'(e_wen));
      chk("ram_d", 64'(ram_d), 64'(e_d));
    end
    if (!rst_n) begin
      m_known = 1; m_run = 0; m_ptr = 0; m_icnt = 0;
      pend.delete();
      m_rdata[0] = '0; m_rdata[1] = '0;
    end else if (!m_run) begin
      ref_mem[m_icnt] = '0;
      if (m_icnt == 15) m_run = 1;
      else m_icnt++;
    end else if (e_g0 || e_g1) begin
      m_ptr = ~gp;
      if (!e_gwen) ref_mem[ga] = (ref_mem[ga] & e_wen) | (e_d & ~e_wen);
      else begin
        rd.due = cyc + 2; rd.port = gp; rd.data = ref_mem[ga];
        pend.push_back(rd);
      end
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_req = 0; p1_req = 0; p0_wr = 0; p1_wr = 0;
  endtask

  // Directed stimulus with hand-computed expectations.
  initial begin
    go(); go();
    #2;
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_ram_cen", 64'(ram_cen), 64'd1);
    chk("rst_p0_rdata", 64'(p0_rdata), 64'd0);

    // Cycle 0: reset released; p0 read of addr 5 waits through INIT.
    go(); rst_n = 1; p0_req = 1; p0_wr = 0; p0_addr = 4'd5;
    #2;
    chk("init_c0_cen", 64'(ram_cen), 64'd0);
    chk("init_c0_a", 64'(ram_a), 64'd0);
    chk("init_c0_gnt", 64'(p0_gnt), 64'd0);
    chk("noinit_c0_done", 64'(init_done2), 64'd0);
    chk("noinit_c0_cen", 64'(ram_cen2), 64'd1);
    go();
    #2;
    chk("noinit_c1_done", 64'(init_done2), 64'd1);
    chk("noinit_c1_cen", 64'(ram_cen2), 64'd1);
    go(); q0_req = 1; q0_addr = 4'd1;
    #2;
    chk("noinit_c2_gnt", 64'(q0_gnt), 64'd1);
    chk("noinit_c2_cen", 64'(ram_cen2), 64'd0);
    go(); q0_req = 0;
    go();
    #2;
    chk("noinit_c4_rvalid", 64'(q0_rvalid), 64'd1);
    chk("noinit_c4_rdata", 64'(q0_rdata), 64'h1234_5678);
    repeat (11) go();
    #2;
    chk("init_c15_a", 64'(ram_a), 64'd15);
    chk("init_c15_done", 64'(init_done), 64'd0);
    go();
    #2;
    chk("run_c16_done", 64'(init_done), 64'd1);
    chk("run_c16_gnt", 64'(p0_gnt), 64'd1);
    go(); idle();
    go();
    #2;
    chk("rd5_rvalid", 64'(p0_rvalid), 64'd1);
    chk("rd5_rdata", 64'(p0_rdata), 64'd0);

    // Write then immediate read of addr 3.
    go(); p0_req = 1; p0_wr = 1; p0_addr = 4'd3; p0_wdata = 32'hA5A5_A5A5; p0_wmask = '1;
    go(); p0_wr = 0;
    go(); idle();
    go();
    #2;
    chk("wr_rd_rvalid", 64'(p0_rvalid), 64'd1);
    chk("wr_rd_rdata", 64'(p0_rdata), 64'hA5A5_A5A5);
    chk("wr_rd_p1_rvalid", 64'(p1_rvalid), 64'd0);

    // Masked write on port 1.
    go(); p1_req = 1; p1_wr = 1; p1_addr = 4'd7; p1_wdata = '1; p1_wmask = '1;
    go(); p1_wdata = '0; p1_wmask = 32'h0000_00FF;
    go(); p1_wr = 0;
    go(); idle();
    go();
    #2;
    chk("mask_rvalid", 64'(p1_rvalid), 64'd1);
    chk("mask_rdata", 64'(p1_rdata), 64'hFFFF_FF00);

    // Contention: both ports read continuously; grants alternate from p0.
    for (int k = 0; k < 6; k++) begin
      go(); p0_req = 1; p0_wr = 0; p0_addr = 4'd3; p1_req = 1; p1_wr = 0; p1_addr = 4'd7;
      #2;
      chk("cont_p0_gnt", 64'(p0_gnt), 64'((k % 2) == 0));
      if (k >= 2) begin
        chk("cont_p0_rvalid", 64'(p0_rvalid), 64'((k % 2) == 0));
        if ((k % 2) == 0) chk("cont_p0_rdata", 64'(p0_rdata), 64'hA5A5_A5A5);
        else              chk("cont_p1_rdata", 64'(p1_rdata), 64'hFFFF_FF00);
      end
    end
    go(); idle();
    go(); go();

    // Reset while a read is in flight.
    go(); p0_req = 1; p0_wr = 0; p0_addr = 4'd3;
    go(); idle(); rst_n = 0;
    #2;
    chk("mid_rst_cen", 64'(ram_cen), 64'd1);
    chk("mid_rst_gnt", 64'(p0_gnt), 64'd0);
    go(); rst_n = 1;
    #2;
    chk("mid_rst_rvalid", 64'(p0_rvalid), 64'd0);
    chk("mid_rst_done", 64'(init_done), 64'd0);
    chk("mid_rst_a", 64'(ram_a), 64'd0);
    chk("mid_rst_cen2", 64'(ram_cen), 64'd0);
    repeat (15) go();
    go(); p0_req = 1; p0_wr = 0; p0_addr = 4'd3;
    #2;
    chk("reinit_gnt", 64'(p0_gnt), 64'd1);
    go(); idle();
    go();
    #2;
    chk("reinit_rvalid", 64'(p0_rvalid), 64'd1);
    chk("reinit_rdata", 64'(p0_rdata), 64'd0);
    go(); go();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
